// File: rtl/lowampa_thresh_servo.sv
// Low-amplitude trigger-rate servo.
// Wishbone initiator that, on every scaler-period-done pulse, reads each beam
// scaler, applies a proportional correction to that beam's shadow threshold,
// writes the threshold back and finally issues the threshold-update command.
//
// Handshake: classic single-transfer Wishbone. A transfer is in progress
// while wb_cyc_o (== wb_stb_o) is high; we/adr/dat stay stable until the edge
// that samples wb_ack_i or wb_err_i, and only one transfer is ever
// outstanding. wb_err_i beats wb_ack_i when both are seen in the same cycle.
module lowampa_thresh_servo #(
  parameter int          NBEAMS      = 54,
  parameter logic [12:0] SCAL_BASE   = 13'h0400,
  parameter logic [12:0] THRESH_BASE = 13'h0800,
  parameter logic [12:0] CTRL_ADDR   = 13'h1800,
  parameter logic [31:0] UPDATE_VAL  = 32'h2,
  parameter logic [17:0] INIT_THRESH = 18'd4000,
  parameter int          GAIN_SHIFT  = 2,
  parameter int          MAX_STEP    = 64,
  parameter int          DEADBAND    = 2,
  parameter int          TIMEOUT     = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [12:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        count_done_i,
  input  logic        servo_en_i,
  input  logic [15:0] target_i,
  input  logic        err_clr_i,
  output logic        busy_o,
  output logic        sweep_done_o,
  output logic        timeout_o,
  output logic        bus_err_o
);

  localparam int BW = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [BW-1:0]      LAST_BEAM = BW'(NBEAMS - 1);
  localparam logic [TW-1:0]      TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic signed [16:0] DB_P      = 17'(DEADBAND);
  localparam logic signed [16:0] DB_N      = -DB_P;
  localparam logic signed [16:0] STEP_P    = 17'(MAX_STEP);
  localparam logic signed [16:0] STEP_N    = -STEP_P;
  localparam logic signed [19:0] THR_MAX   = 20'sd262143;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_SCAL = 3'd1,
    S_CALC    = 3'd2,
    S_WR_THR  = 3'd3,
    S_GAP     = 3'd4,
    S_WR_UPD  = 3'd5
  } state_t;

  state_t state;
  state_t state_next;

  logic [BW-1:0] beam;
  logic          pending;
  logic [15:0]   count;
  logic [TW-1:0] tcnt;
  logic [17:0]   shadow [NBEAMS];

  logic               bus_act;
  logic               xfer_ack;
  logic               xfer_err;
  logic               xfer_tmo;
  logic               req;
  logic               start;
  logic               last_beam;
  logic [12:0]        beam_ofs;
  logic signed [16:0] err_s;
  logic signed [16:0] err_sh;
  logic signed [16:0] delta;
  logic signed [19:0] sum_s;
  logic [17:0]        thresh_new;

  // Upper half of the scaler word carries no count information.
  logic unused_dat_hi;
  assign unused_dat_hi = ^wb_dat_i[31:16];

  // Transfer-completion events and sweep-start decision.
  always_comb begin
    bus_act   = (state == S_RD_SCAL) || (state == S_WR_THR) || (state == S_WR_UPD);
    xfer_err  = bus_act && wb_err_i;
    xfer_ack  = bus_act && wb_ack_i && !wb_err_i;
    xfer_tmo  = bus_act && !wb_ack_i && !wb_err_i && (tcnt == TMO_LAST);
    req       = count_done_i || pending;
    start     = (state == S_IDLE) && req && servo_en_i;
    last_beam = (beam == LAST_BEAM);
    beam_ofs  = 13'({beam, 2'b00});
  end

  // Proportional correction with deadband, step clamp and 18-bit saturation.
  always_comb begin
    err_s  = $signed({1'b0, count}) - $signed({1'b0, target_i});
    err_sh = err_s >>> GAIN_SHIFT;
    if (err_s >= DB_N && err_s <= DB_P) begin
      delta = '0;
    end else if (err_sh > STEP_P) begin
      delta = STEP_P;
    end else if (err_sh < STEP_N) begin
      delta = STEP_N;
    end else begin
      delta = err_sh;
    end
    sum_s = $signed({2'b00, shadow[beam]}) + $signed({{3{delta[16]}}, delta});
    if (sum_s < 20'sd0) begin
      thresh_new = '0;
    end else if (sum_s > THR_MAX) begin
      thresh_new = '1;
    end else begin
      thresh_new = sum_s[17:0];
    end
  end

  // Sweep sequencer next-state; any error or timeout abandons the sweep.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_RD_SCAL;
      end
      S_RD_SCAL: begin
        if (xfer_err || xfer_tmo) state_next = S_IDLE;
        else if (xfer_ack)        state_next = S_CALC;
      end
      S_CALC: begin
        state_next = S_WR_THR;
      end
      S_WR_THR: begin
        if (xfer_err || xfer_tmo) state_next = S_IDLE;
        else if (xfer_ack)        state_next = last_beam ? S_WR_UPD : S_GAP;
      end
      S_GAP: begin
        state_next = S_RD_SCAL;
      end
      S_WR_UPD: begin
        if (xfer_err || xfer_tmo || xfer_ack) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Bus drive decoded from the state register so fields hold for the whole transfer.
  always_comb begin
    wb_cyc_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_adr_o = '0;
    wb_dat_o = '0;
    case (state)
      S_RD_SCAL: begin
        wb_cyc_o = 1'b1;
        wb_adr_o = SCAL_BASE + beam_ofs;
      end
      S_WR_THR: begin
        wb_cyc_o = 1'b1;
        wb_we_o  = 1'b1;
        wb_adr_o = THRESH_BASE + beam_ofs;
        wb_dat_o = {14'b0, shadow[beam]};
      end
      S_WR_UPD: begin
        wb_cyc_o = 1'b1;
        wb_we_o  = 1'b1;
        wb_adr_o = CTRL_ADDR;
        wb_dat_o = UPDATE_VAL;
      end
      default: begin
      end
    endcase
  end

  assign wb_stb_o = wb_cyc_o;
  assign wb_sel_o = 4'hF;
  assign busy_o   = (state != S_IDLE);

  // State register, beam index, request latch, ack timer and status flags.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state        <= S_IDLE;
      beam         <= '0;
      pending      <= 1'b0;
      count        <= '0;
      tcnt         <= '0;
      sweep_done_o <= 1'b0;
      timeout_o    <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      state        <= state_next;
      sweep_done_o <= (state == S_WR_UPD) && xfer_ack;

      if (start) begin
        beam <= '0;
      end else if ((state == S_WR_THR) && xfer_ack && !last_beam) begin
        beam <= beam + 1'b1;
      end

      // A request arriving mid-sweep is held (single-deep) until back in IDLE,
      // where it is consumed whether or not the servo is enabled.
      if (state == S_IDLE) begin
        pending <= 1'b0;
      end else if (count_done_i) begin
        pending <= 1'b1;
      end

      if ((state == S_RD_SCAL) && xfer_ack) begin
        count <= wb_dat_i[15:0];
      end

      // Timer restarts with every transfer, including back-to-back ones.
      if (!bus_act || xfer_ack || xfer_err || xfer_tmo) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end

      if (xfer_tmo)       timeout_o <= 1'b1;
      else if (err_clr_i) timeout_o <= 1'b0;

      if (xfer_err)       bus_err_o <= 1'b1;
      else if (err_clr_i) bus_err_o <= 1'b0;
    end
  end

  // Shadow thresholds: updated once per beam in CALC, reloaded on reset.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      for (int i = 0; i < NBEAMS; i++) begin
        shadow[i] <= INIT_THRESH;
      end
    end else if (state == S_CALC) begin
      shadow[beam] <= thresh_new;
    end
  end

endmodule

// File: tb/tb_lowampa_thresh_servo.sv
// Bench for lowampa_thresh_servo: a randomized-latency Wishbone target with
// fault injection, a spec-level threshold model feeding an expected-transfer
// queue, and a second instance preset near full scale for saturation.
module tb_lowampa_thresh_servo;

  localparam int NB = 2;
  localparam int W  = 46;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic        cyc, stb, we, ack, err;
  logic [12:0] adr;
  logic [31:0] dat_o, dat_i;
  logic [3:0]  sel;
  logic        count_done, servo_en, err_clr;
  logic [15:0] target;
  logic        busy, sweep_done, timeout, bus_err;

  lowampa_thresh_servo #(.NBEAMS(NB)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr),
    .wb_dat_o(dat_o), .wb_sel_o(sel), .wb_dat_i(dat_i), .wb_ack_i(ack),
    .wb_err_i(err), .count_done_i(count_done), .servo_en_i(servo_en),
    .target_i(target), .err_clr_i(err_clr), .busy_o(busy),
    .sweep_done_o(sweep_done), .timeout_o(timeout), .bus_err_o(bus_err)
  );

  // ---------------- saturation DUT ----------------
  logic        cyc2, stb2, we2, ack2;
  logic [12:0] adr2;
  logic [31:0] dat2_o;
  logic [3:0]  sel2;
  logic        count_done2;
  logic        busy2, sweep_done2, timeout2, bus_err2;

  lowampa_thresh_servo #(.NBEAMS(1), .INIT_THRESH(18'd262140)) dut2 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wb_cyc_o(cyc2), .wb_stb_o(stb2), .wb_we_o(we2), .wb_adr_o(adr2),
    .wb_dat_o(dat2_o), .wb_sel_o(sel2), .wb_dat_i(32'h0000FFFF), .wb_ack_i(ack2),
    .wb_err_i(1'b0), .count_done_i(count_done2), .servo_en_i(1'b1),
    .target_i(16'd0), .err_clr_i(1'b0), .busy_o(busy2),
    .sweep_done_o(sweep_done2), .timeout_o(timeout2), .bus_err_o(bus_err2)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errs   = 0;
  logic [W-1:0] exp_q[$];
  int scal[NB];
  int m_shadow[NB];
  int wr_thr[NB];
  int ctrl_cnt     = 0;
  int xfer_total   = 0;
  int xfer_idx     = 0;
  int noack_idx    = -1;
  int err_idx      = -1;
  int max_wait     = 0;
  int abort_cycles = 0;
  int n_sweeps     = 0;
  int wr2_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One sweep of expected bus traffic; fault_idx marks the transfer that will
  // be aborted (it still appears on the bus, nothing after it does).
  task automatic model_sweep(input int fault_idx);
    int idx, e, d, n;
    idx = 0;
    for (int b = 0; b < NB; b++) begin
      exp_q.push_back({1'b0, 13'('h400 + 4 * b), 32'h0});
      if (idx == fault_idx) return;
      idx++;
      e = scal[b] - int'(target);
      if (e >= -2 && e <= 2) d = 0;
      else begin
        d = e >>> 2;
        if (d > 64)  d = 64;
        if (d < -64) d = -64;
      end
      n = m_shadow[b] + d;
      if (n < 0)      n = 0;
      if (n > 262143) n = 262143;
      m_shadow[b] = n;
      exp_q.push_back({1'b1, 13'('h800 + 4 * b), 32'(n)});
      if (idx == fault_idx) return;
      idx++;
    end
    exp_q.push_back({1'b1, 13'h1800, 32'h2});
  endtask

  // ---------------- main Wishbone target ----------------
  initial begin : slave
    logic        done_prev, in_xfer, s_we;
    logic [12:0] s_adr;
    logic [31:0] s_dat;
    logic [W-1:0] got;
    int wait_cnt, cyc_cycles, this_idx, bi;
    ack = 1'b0; err = 1'b0; dat_i = '0;
    in_xfer = 1'b0; wait_cnt = 0; cyc_cycles = 0; this_idx = 0;
    s_we = 1'b0; s_adr = '0; s_dat = '0;
    forever begin
      @(posedge clk); #1;
      done_prev = ack | err;
      ack = 1'b0;
      err = 1'b0;
      if (cyc) begin
        if (!in_xfer || done_prev) begin
          in_xfer = 1'b1; s_we = we; s_adr = adr; s_dat = dat_o; cyc_cycles = 0;
          wait_cnt = $urandom_range(0, max_wait);
          this_idx = xfer_idx; xfer_idx++; xfer_total++;
          got = {s_we, s_adr, s_we ? s_dat : 32'h0};
          if (exp_q.size() == 0) check_eq("xfer_unexpected", 64'(got), 64'd0);
          else check_eq("xfer", 64'(got), 64'(exp_q.pop_front()));
          check_eq("sel", 64'(sel), 64'hF);
          bi = (int'(s_adr) - 'h800) / 4;
          if (s_we && s_adr >= 13'h800 && bi < NB) wr_thr[bi] = int'(s_dat);
          if (s_we && s_adr == 13'h1800) ctrl_cnt++;
        end
        cyc_cycles++;
        if (this_idx != noack_idx) begin
          if (wait_cnt == 0) begin
            check_eq("hold", 64'({stb, we, adr, dat_o}), 64'({1'b1, s_we, s_adr, s_dat}));
            if (this_idx == err_idx) err = 1'b1;
            else begin
              ack = 1'b1;
              bi = (int'(adr) - 'h400) / 4;
              if (!we && adr >= 13'h400 && bi < NB) dat_i = {16'($urandom), 16'(scal[bi])};
            end
          end else begin
            wait_cnt--;
          end
        end
      end else begin
        if (in_xfer && !done_prev) abort_cycles = cyc_cycles;
        in_xfer = 1'b0;
      end
    end
  end

  // ---------------- saturation-instance target (zero wait) ----------------
  initial begin : slave2
    logic prev;
    ack2 = 1'b0;
    forever begin
      @(posedge clk); #1;
      prev = ack2;
      ack2 = cyc2 && !prev;
      if (ack2) begin
        check_eq("dut2_sel", 64'(sel2), 64'hF);
        check_eq("dut2_stb", 64'(stb2), 64'(cyc2));
        if (we2 && adr2 == 13'h0800) wr2_q.push_back(int'(dat2_o));
      end
    end
  end

  // Sweep-completion monitor.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (sweep_done) n_sweeps++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_cd();
    @(negedge clk); count_done = 1'b1;
    @(negedge clk); count_done = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
  endtask

  task automatic wait_sweeps(input int want, input int budget, input int drop_en_at);
    for (int c = 0; c < budget && n_sweeps < want; c++) begin
      @(negedge clk);
      if (c == drop_en_at) servo_en = 1'b0;
    end
    check_eq("sweep_seen", 64'(n_sweeps >= want), 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    for (int c = 0; c < budget && busy; c++) @(negedge clk);
    check_eq("idle_reached", 64'(busy), 64'd0);
  endtask

  task automatic run_sweep(input int drop_en_at);
    int base;
    base = n_sweeps;
    xfer_idx = 0;
    model_sweep(-1);
    pulse_cd();
    wait_sweeps(base + 1, 2000, drop_en_at);
    check_eq("done_busy", 64'(busy), 64'd0);
    check_eq("done_pulse", 64'(sweep_done), 64'd1);
    @(negedge clk);
    check_eq("done_width", 64'(sweep_done), 64'd0);
    check_eq("exp_drained", 64'(exp_q.size()), 64'd0);
    servo_en = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base, ctrl_base, xb, v;
    rst_n = 1'b0; count_done = 1'b1; servo_en = 1'b1; err_clr = 1'b0;
    target = 16'd0; count_done2 = 1'b0;
    for (int b = 0; b < NB; b++) begin
      m_shadow[b] = 4000; scal[b] = 0; wr_thr[b] = -1;
    end

    // Reset held with a scaler-done request present.
    repeat (4) @(negedge clk);
    check_eq("rst_cyc", 64'(cyc), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(sweep_done), 64'd0);
    check_eq("rst_tmo", 64'(timeout), 64'd0);
    check_eq("rst_berr", 64'(bus_err), 64'd0);
    count_done = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("rst_no_xfer", 64'(xfer_total), 64'd0);
    check_eq("rst_busy_after", 64'(busy), 64'd0);

    // Directed sweep: target 100, scalers 140/60.
    target = 16'd100; scal[0] = 140; scal[1] = 60;
    ctrl_base = ctrl_cnt;
    run_sweep(-1);
    check_eq("dir_thr0", 64'(wr_thr[0]), 64'd4010);
    check_eq("dir_thr1", 64'(wr_thr[1]), 64'd3990);
    check_eq("dir_ctrl", 64'(ctrl_cnt - ctrl_base), 64'd1);

    // Deadband edge (+2 -> none) and first step past it (-3 -> -1).
    scal[0] = 102; scal[1] = 97;
    run_sweep(-1);
    check_eq("db_thr0", 64'(wr_thr[0]), 64'd4010);
    check_eq("db_thr1", 64'(wr_thr[1]), 64'd3989);

    // Disabled: the request is dropped, not deferred.
    xb = xfer_total;
    servo_en = 1'b0;
    pulse_cd();
    repeat (20) @(negedge clk);
    check_eq("dis_no_xfer", 64'(xfer_total - xb), 64'd0);
    check_eq("dis_busy", 64'(busy), 64'd0);
    servo_en = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("dis_not_pending", 64'(xfer_total - xb), 64'd0);

    // Two extra pulses mid-sweep merge into one further sweep.
    max_wait = 2;
    base = n_sweeps; xfer_idx = 0;
    scal[0] = 500; scal[1] = 20;
    model_sweep(-1);
    model_sweep(-1);
    pulse_cd();
    check_eq("pend_busy1", 64'(busy), 64'd1);
    pulse_cd();
    check_eq("pend_busy2", 64'(busy), 64'd1);
    pulse_cd();
    wait_sweeps(base + 2, 800, -1);
    repeat (60) @(negedge clk);
    check_eq("pend_sweeps", 64'(n_sweeps - base), 64'd2);
    check_eq("pend_exp", 64'(exp_q.size()), 64'd0);

    // Randomized sweeps with variable ack latency and enable dropped mid-sweep.
    for (int i = 0; i < 30; i++) begin
      max_wait = $urandom_range(0, 3);
      target = 16'($urandom_range(0, 65535));
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 65535);
        else v = int'(target) + $urandom_range(0, 600) - 300;
        if (v < 0) v = 0;
        if (v > 65535) v = 65535;
        scal[b] = v;
      end
      run_sweep(($urandom_range(0, 1) == 1) ? $urandom_range(0, 8) : -1);
    end

    // Ack timeout on beam 1 scaler read.
    max_wait = 0; noack_idx = 2; xfer_idx = 0;
    base = n_sweeps; ctrl_base = ctrl_cnt;
    model_sweep(2);
    pulse_cd();
    wait_idle(600);
    check_eq("tmo_cycles", 64'(abort_cycles), 64'd255);
    check_eq("tmo_flag", 64'(timeout), 64'd1);
    check_eq("tmo_cyc", 64'(cyc), 64'd0);
    check_eq("tmo_no_ctrl", 64'(ctrl_cnt - ctrl_base), 64'd0);
    check_eq("tmo_no_done", 64'(n_sweeps - base), 64'd0);
    check_eq("tmo_exp", 64'(exp_q.size()), 64'd0);
    noack_idx = -1;
    pulse_clr();
    check_eq("tmo_clr", 64'(timeout), 64'd0);

    // Bus error on beam 0 threshold write.
    err_idx = 1; xfer_idx = 0; ctrl_base = ctrl_cnt;
    model_sweep(1);
    pulse_cd();
    wait_idle(50);
    check_eq("berr_flag", 64'(bus_err), 64'd1);
    check_eq("berr_cyc", 64'(cyc), 64'd0);
    check_eq("berr_no_ctrl", 64'(ctrl_cnt - ctrl_base), 64'd0);
    check_eq("berr_tmo", 64'(timeout), 64'd0);
    err_idx = -1;
    pulse_clr();
    check_eq("berr_clr", 64'(bus_err), 64'd0);

    // Reset in the middle of a transfer discards the sweep and the shadows.
    noack_idx = 0; xfer_idx = 0;
    model_sweep(0);
    pulse_cd();
    for (int c = 0; c < 20 && !cyc; c++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_cyc", 64'(cyc), 64'd0);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    noack_idx = -1;
    for (int b = 0; b < NB; b++) m_shadow[b] = 4000;

    // Positive clamp: full-scale error gives +64 per sweep.
    target = 16'd0; scal[0] = 65535; scal[1] = 65535;
    run_sweep(-1);
    check_eq("clamp_thr0", 64'(wr_thr[0]), 64'd4064);
    check_eq("clamp_thr1", 64'(wr_thr[1]), 64'd4064);

    // Negative clamp down to the zero floor.
    target = 16'd65535; scal[0] = 0; scal[1] = 0;
    for (int i = 0; i < 70; i++) run_sweep(-1);
    check_eq("floor_thr0", 64'(wr_thr[0]), 64'd0);
    check_eq("floor_thr1", 64'(wr_thr[1]), 64'd0);

    // Ceiling: shadow preset 262140 saturates at 262143.
    for (int s = 0; s < 2; s++) begin
      @(negedge clk); count_done2 = 1'b1;
      @(negedge clk); count_done2 = 1'b0;
      repeat (30) @(negedge clk);
    end
    check_eq("sat_writes", 64'(wr2_q.size()), 64'd2);
    if (wr2_q.size() >= 2) begin
      check_eq("sat_first", 64'(wr2_q[0]), 64'd262143);
      check_eq("sat_second", 64'(wr2_q[1]), 64'd262143);
    end
    check_eq("sat_busy", 64'(busy2), 64'd0);
    check_eq("sat_flags", 64'({timeout2, bus_err2, sweep_done2}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #900000;
    $display("FAIL watchdog expired n_checks=%0d n_errs=%0d", n_checks, n_errs);
    $fatal(1, "watchdog");
  end

endmodule
